// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding, parity constants and helpers for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int c_OVERSAMPLE_DEFAULT = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : edge_bit_counter
// Brief    : Oversample edge counter and data-bit counter for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
module edge_bit_counter #(
    parameter int EDGE_W = 3,
    parameter int BIT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_edge_en,
    input  logic              i_bit_inc,
    input  logic              i_bit_clr,
    output logic [EDGE_W-1:0] o_edge_cnt,
    output logic [BIT_W-1:0]  o_bit_cnt
);

    logic [EDGE_W-1:0] r_edge_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            // Power-of-two oversampling lets the count wrap to 0 exactly at each bit boundary
            if (i_edge_en) begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end else begin
                r_edge_cnt <= '0;
            end
            if (i_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (i_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with majority vote, parity and stop checks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int Width      = 8,
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             par_en,
    input  logic             par_typ,
    output logic [Width-1:0] p_data,
    output logic             data_valid,
    output logic             par_err,
    output logic             stop_err
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(Width + 1);

    localparam logic [EW-1:0] c_SAMP0 = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] c_SAMP1 = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] c_SAMP2 = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] c_LAST  = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(Width - 1);

    uart_state_e r_state;
    uart_state_e w_state_nxt;

    logic [EW-1:0]    w_edge_cnt;
    logic [BW-1:0]    w_bit_cnt;
    logic             w_start_det;
    logic             w_last_edge;
    logic             w_bit_adv;
    logic             w_frame_done;
    logic             w_par_exp;

    logic [1:0]       r_samp;
    logic             r_bit;
    logic             r_par_en;
    logic             r_par_typ;
    logic             r_par_bad;
    logic             r_done;
    logic             r_stop_bad;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] r_p_data;
    logic             r_data_valid;
    logic             r_par_err;
    logic             r_stop_err;

    assign w_start_det  = (r_state == IDLE) && !rx_in;
    assign w_last_edge  = (w_edge_cnt == c_LAST);
    assign w_bit_adv    = (r_state == DATA) && w_last_edge;
    assign w_frame_done = (r_state == STOP) && w_last_edge;
    assign w_par_exp    = (^r_shift) ^ (r_par_typ == ODD);

    edge_bit_counter #(
        .EDGE_W (EW),
        .BIT_W  (BW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_edge_en  ((r_state != IDLE) || w_start_det),
        .i_bit_inc  (w_bit_adv),
        .i_bit_clr  (r_state != DATA),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_det) w_state_nxt = START;
            START:   if (w_last_edge) w_state_nxt = r_bit ? IDLE : DATA;
            DATA:    if (w_last_edge && (w_bit_cnt == c_LAST_BIT))
                         w_state_nxt = r_par_en ? PARITY : STOP;
            PARITY:  if (w_last_edge) w_state_nxt = STOP;
            STOP:    if (w_last_edge) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Voted bit is registered on the third sample, so it is usable from OVERSAMPLE/2+2
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_samp <= '0;
            r_bit  <= 1'b0;
        end else if (r_state != IDLE) begin
            if (w_edge_cnt == c_SAMP0) r_samp[0] <= rx_in;
            if (w_edge_cnt == c_SAMP1) r_samp[1] <= rx_in;
            if (w_edge_cnt == c_SAMP2) r_bit     <= maj3(r_samp[0], r_samp[1], rx_in);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
                r_par_bad <= 1'b0;
            end
            if (w_bit_adv) begin
                r_shift <= {r_bit, r_shift[Width-1:1]};
            end
            if ((r_state == PARITY) && w_last_edge) begin
                r_par_bad <= (r_bit != w_par_exp);
            end
            r_done     <= w_frame_done;
            r_stop_bad <= w_frame_done && !r_bit;
        end
    end

    // Results settle one edge after the stop bit ends, keeping the IDLE entry cycle free for a new start
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_stop_err   <= r_done && r_stop_bad;
            r_par_err    <= r_done && !r_stop_bad && r_par_bad;
            r_data_valid <= r_done && !r_stop_bad && !r_par_bad;
            if (r_done && !r_stop_bad && !r_par_bad) begin
                r_p_data <= r_shift;
            end
        end
    end

    assign p_data     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stop_err   = r_stop_err;

endmodule
`default_nettype wire
